// File: rtl/regfile_wr_arb_pkg.sv
// Shared types for the register-file write-port arbiter and its result FIFO.
package regfile_wr_arb_pkg;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } rf_wr_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_MD
  } arb_gnt_t;

  // Register 0 is hardwired, so a write to it never needs the port.
  function automatic logic needs_port(input logic valid, input logic [4:0] dst);
    return valid && (dst != 5'd0);
  endfunction

endpackage

// File: rtl/regfile_wr_arb_if.sv
// Writeback, long-latency and register-file write signals of the arbiter.
// RF_ARB_PENDING_CHECK_EN adds the decode pending-hit lookup signals.
interface regfile_wr_arb_if;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        arb_stall;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef RF_ARB_PENDING_CHECK_EN
  logic [4:0]  pend_rs1;
  logic [4:0]  pend_rs2;
  logic        pend_hit1;
  logic        pend_hit2;

  modport master (
    output wb_valid, wb_reg, wb_data, md_valid, md_reg, md_data, pend_rs1, pend_rs2,
    input  arb_stall, md_ready, rf_we, rf_waddr, rf_wdata, pend_hit1, pend_hit2
  );
  modport slave (
    input  wb_valid, wb_reg, wb_data, md_valid, md_reg, md_data, pend_rs1, pend_rs2,
    output arb_stall, md_ready, rf_we, rf_waddr, rf_wdata, pend_hit1, pend_hit2
  );
`else
  modport master (
    output wb_valid, wb_reg, wb_data, md_valid, md_reg, md_data,
    input  arb_stall, md_ready, rf_we, rf_waddr, rf_wdata
  );
  modport slave (
    input  wb_valid, wb_reg, wb_data, md_valid, md_reg, md_data,
    output arb_stall, md_ready, rf_we, rf_waddr, rf_wdata
  );
`endif
endinterface

// File: rtl/rf_wr_fifo.sv
// Strict-order FIFO of pending long-latency register writes.
// RF_ARB_PENDING_CHECK_EN exposes every entry and its valid bit.
module rf_wr_fifo
  import regfile_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  rf_wr_t                   push_data_i,
  output rf_wr_t                   head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [AW:0]              count_o
`ifdef RF_ARB_PENDING_CHECK_EN
  ,
  output rf_wr_t [DEPTH-1:0]       entries_o,
  output logic   [DEPTH-1:0]       entry_vld_o
`endif
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  rf_wr_t        mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

`ifdef RF_ARB_PENDING_CHECK_EN
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] offs;
      assign offs            = AW'(gi) - rd_ptr_q;
      assign entries_o[gi]   = mem_q[gi];
      assign entry_vld_o[gi] = ({1'b0, offs} < count_q);
    end
  endgenerate
`endif

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: retirement first, queued long-latency results drain when idle, full or starved.
// RF_ARB_PENDING_CHECK_EN adds the combinational pending-register lookup for decode.
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk_core,
  input logic              reset,
  regfile_wr_arb_if.slave  bus
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

  arb_gnt_t     gnt;
  logic         pipe_need, force_md;
  logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AW:0]  fifo_count;
  rf_wr_t       fifo_head, push_entry;
  logic [3:0]   starve_q, starve_d;
  logic         rf_we_q, rf_we_d;
  logic [4:0]   rf_waddr_q, rf_waddr_d;
  logic [31:0]  rf_wdata_q, rf_wdata_d;

  assign pipe_need  = needs_port(bus.wb_valid, bus.wb_reg);
  assign bus.md_ready = (fifo_count != CNT_FULL);
  // Writes to r0 are acknowledged but never queued.
  assign fifo_push  = bus.md_valid && bus.md_ready && (bus.md_reg != 5'd0);
  assign push_entry = '{dst: bus.md_reg, data: bus.md_data};
  assign fifo_pop   = (gnt == GNT_MD);

`ifdef RF_ARB_PENDING_CHECK_EN
  rf_wr_t [DEPTH-1:0] fifo_entries;
  logic   [DEPTH-1:0] fifo_vld;
`endif

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk_core),
    .rst         (reset),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .push_data_i (push_entry),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
`ifdef RF_ARB_PENDING_CHECK_EN
    ,
    .entries_o   (fifo_entries),
    .entry_vld_o (fifo_vld)
`endif
  );

  always_comb begin
    gnt      = GNT_NONE;
    force_md = 1'b0;
    if (fifo_empty) begin
      if (pipe_need) gnt = GNT_PIPE;
    end else if (!pipe_need) begin
      gnt = GNT_MD;
    end else if (fifo_full || (starve_q == STARVE_LIM)) begin
      gnt      = GNT_MD;
      force_md = 1'b1;
    end else begin
      gnt = GNT_PIPE;
    end
  end

  assign bus.arb_stall = force_md;

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || (gnt == GNT_MD)) begin
      starve_d = 4'd0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (gnt)
      GNT_PIPE: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = bus.wb_reg;
        rf_wdata_d = bus.wb_data;
      end
      GNT_MD: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = fifo_head.dst;
        rf_wdata_d = fifo_head.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      starve_q   <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

`ifdef RF_ARB_PENDING_CHECK_EN
  logic [DEPTH-1:0] hit1_vec, hit2_vec;

  // The head being popped this cycle still reports as pending.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
      assign hit1_vec[gi] = fifo_vld[gi] && (fifo_entries[gi].dst == bus.pend_rs1);
      assign hit2_vec[gi] = fifo_vld[gi] && (fifo_entries[gi].dst == bus.pend_rs2);
    end
  endgenerate

  assign bus.pend_hit1 = (|hit1_vec) && (bus.pend_rs1 != 5'd0);
  assign bus.pend_hit2 = (|hit2_vec) && (bus.pend_rs2 != 5'd0);
`endif

endmodule

// File: doc/regfile_wr_arb.md
# regfile_wr_arb

Arbiter for the single register-file write port. Two requesters share it: the in-order retirement stream from the writeback stage and a long-latency unit (multiply/divide) that returns results out of band. Retirement normally wins. Long-latency results wait in a small FIFO and drain when the port is idle, when the FIFO is full, or when a starvation bound expires; in the last two cases the writeback stage is stalled for one cycle.

## Interface
Parameters:
- DEPTH, 2 — long-latency result FIFO entries; power of two, at least 2
- STARVE_MAX, 4 — cycles a non-empty FIFO may be denied before it is forced through; range 1..15

Ports:
- clk_core  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  writeback stage holds a retiring instruction
- wb_reg  in  5  destination register of the retiring instruction
- wb_data  in  32  result of the retiring instruction
- arb_stall  out  1  holds the writeback stage this cycle (combinational)
- md_valid  in  1  long-latency result offered
- md_ready  out  1  FIFO can accept a result
- md_reg  in  5  long-latency destination register
- md_data  in  32  long-latency result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- pend_rs1, pend_rs2  in  5  decode source registers (only with the macro enabled)
- pend_hit1, pend_hit2  out  1  the source register has a result still queued in the FIFO (only with the macro enabled)

## Operation
- FIFO push: when md_valid & md_ready.
  - md_ready = ~full, from the registered count.
  - A push with md_reg==0 is accepted and discarded; it never enters the FIFO.
- Pipeline port need: pipe_need = wb_valid & (wb_reg != 0).
- Grant, evaluated every cycle:
  - FIFO empty: the pipeline gets the port when pipe_need.
  - FIFO non-empty and ~pipe_need: the FIFO head pops; no stall.
  - FIFO non-empty, pipe_need, and (full or starve_cnt == STARVE_MAX): the FIFO head pops and arb_stall=1.
  - Otherwise the pipeline gets the port.
- A wb_valid entry with wb_reg==0 completes without a write and never stalls.
- arb_stall is asserted only on a forced FIFO grant.
- starve_cnt:
  - Increments when the FIFO is non-empty and not granted.
  - Clears on a FIFO grant, or whenever the FIFO is empty.
  - Saturates at STARVE_MAX.
- FIFO order is strict; entries are never reordered or merged. Write-after-write ordering between the two sources is the upstream scoreboard's responsibility.
- Push and pop in the same cycle on a non-full FIFO leave the count unchanged. On a full FIFO the pop happens and the push is refused (md_ready=0 that cycle).
- Reset: FIFO emptied, starve_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, arb_stall=0, md_ready=1.
  - Reset mid-operation drops all queued results.

## Timing
- Pipeline grant in cycle N: rf_we/rf_waddr/rf_wdata valid in cycle N+1.
- Long-latency push in cycle N: the earliest pop is N+1, so the earliest rf_we is N+2.
- Forced grant: arb_stall is high in the same cycle. The writeback stage repeats its entry, and that entry is granted in cycle N+1 unless the FIFO is still full.
- Worst-case pipeline delay from a single forced drain: one cycle per forced grant.
- Worst-case FIFO residency with wb_valid continuously high: STARVE_MAX+1 cycles per entry.

## Configuration
- Macro RF_ARB_PENDING_CHECK_EN.
- Defined: the pend_rs1/pend_rs2 inputs and pend_hit1/pend_hit2 outputs exist.
  - pend_hitX = 1 when any valid FIFO entry has reg == pend_rsX and pend_rsX != 0.
  - The entry being popped this cycle still counts as a hit.
  - Purely combinational.
- Undefined: those ports and the comparison logic are absent; decode relies on the scoreboard alone.

## Structure
- Shared package:
  - rf_wr_t struct (reg[4:0], data[31:0])
  - arb_gnt_t enum (GNT_NONE, GNT_PIPE, GNT_MD)
- Sub-module rf_wr_fifo: synchronous FIFO of rf_wr_t.
  - Ports: push/pop, head, full/empty, count.
  - Exposes entry contents for the pending check.
- Grant logic, starvation counter and output registers live in regfile_wr_arb.

## Test plan
- Idle FIFO: wb_valid with wb_reg=5, wb_data=0x11 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11; arb_stall stays 0.
- md push (reg 7, data 0xAA) while wb_valid=0 -> rf_we with waddr 7 exactly two cycles after the push.
- STARVE_MAX=4, one queued entry, wb_valid continuously high with nonzero regs -> arb_stall=1 on the 5th cycle, that cycle's rf write is the queued entry, and the pipeline entry writes the following cycle.
- Fill FIFO to DEPTH=2 with wb_valid high -> md_ready=0; a forced drain with arb_stall=1 occurs the next cycle, then md_ready returns to 1.
- wb_valid with wb_reg=0 while the FIFO is non-empty -> the FIFO drains with no stall; md push with md_reg=0 -> accepted, no rf_we ever.
- Assert reset with 2 entries queued and starve_cnt=3 -> immediately rf_we=0, md_ready=1, and after release no queued write appears. With the macro: pend_hit1=1 for a queued reg before the reset, 0 after.
